// File: rtl/config_shifter.sv
// Configuration chain loader: serializes host bytes LSB-first onto the shift
// chain head and packs the bits displaced from the chain tail into readback bytes.
module config_shifter #(
  parameter int unsigned CHAIN_LENGTH = 1040,
  parameter int unsigned COUNT_WIDTH  = 11
) (
  input  logic                   shift_clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             byte_data,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic                   shift_data,
  output logic                   shift_enable,
  input  logic                   chain_return,
  output logic [7:0]             readback_data,
  output logic                   readback_valid,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] bit_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] LAST_BIT = COUNT_WIDTH'(CHAIN_LENGTH);

  state_t                 state_q, state_d;
  logic [7:0]             tx_q, tx_d;
  logic [7:0]             rx_q, rx_d;
  logic [7:0]             rb_q, rb_d;
  logic                   rbv_q, rbv_d;
  logic [2:0]             bib_q, bib_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] cnt_inc;
  logic [7:0]             rx_next;

  assign cnt_inc = cnt_q + COUNT_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rb_d    = rb_q;
    rbv_d   = 1'b0;
    bib_d   = bib_q;
    cnt_d   = cnt_q;
    rx_next = rx_q;
    rx_next[bib_q] = chain_return;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (byte_valid) begin
          tx_d    = byte_data;
          rx_d    = '0;
          bib_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        tx_d  = {1'b0, tx_q[7:1]};
        rx_d  = rx_next;
        bib_d = bib_q + 3'd1;
        cnt_d = cnt_inc;
        // The chain-length test wins over the byte boundary, so a short final
        // byte ends the load and its unfilled rx bits stay at their cleared 0.
        if (cnt_inc == LAST_BIT) begin
          rb_d    = rx_next;
          rbv_d   = 1'b1;
          state_d = DONE;
        end else if (bib_q == 3'd7) begin
          rb_d    = rx_next;
          rbv_d   = 1'b1;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge shift_clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      rb_q    <= '0;
      rbv_q   <= 1'b0;
      bib_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rb_q    <= rb_d;
      rbv_q   <= rbv_d;
      bib_q   <= bib_d;
      cnt_q   <= cnt_d;
    end
  end

  assign byte_ready     = (state_q == LOAD);
  assign shift_enable   = (state_q == SHIFT);
  assign shift_data     = (state_q == SHIFT) & tx_q[0];
  assign busy           = (state_q == LOAD) || (state_q == SHIFT);
  assign done           = (state_q == DONE);
  assign readback_data  = rb_q;
  assign readback_valid = rbv_q;
  assign bit_count      = cnt_q;

endmodule

// File: tb/tb_config_shifter.sv
// Bench for config_shifter: two instances (16-bit and 12-bit chains) driven
// against a behavioural fabric chain and a bit-list reference model.
module tb_config_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [1:0]      start_s, bv, br, sd, se, rbv, busy_s, done_s, cr;
  logic [1:0][7:0] bd, rbd;
  logic [4:0]      bc0;
  logic [3:0]      bc1;

  config_shifter #(.CHAIN_LENGTH(16), .COUNT_WIDTH(5)) u16 (
    .shift_clock(clk), .reset(reset), .start(start_s[0]),
    .byte_data(bd[0]), .byte_valid(bv[0]), .byte_ready(br[0]),
    .shift_data(sd[0]), .shift_enable(se[0]), .chain_return(cr[0]),
    .readback_data(rbd[0]), .readback_valid(rbv[0]), .busy(busy_s[0]),
    .done(done_s[0]), .bit_count(bc0)
  );

  config_shifter #(.CHAIN_LENGTH(12), .COUNT_WIDTH(4)) u12 (
    .shift_clock(clk), .reset(reset), .start(start_s[1]),
    .byte_data(bd[1]), .byte_valid(bv[1]), .byte_ready(br[1]),
    .shift_data(sd[1]), .shift_enable(se[1]), .chain_return(cr[1]),
    .readback_data(rbd[1]), .readback_valid(rbv[1]), .busy(busy_s[1]),
    .done(done_s[1]), .bit_count(bc1)
  );

  // Fabric chain: bits enter at the top, the tail bit is bit 0.
  logic [15:0] chain0 = '0;
  logic [11:0] chain1 = '0;
  logic [1:0]  pl = '0;
  logic [15:0] plv = '0;
  always @(posedge clk) begin
    if (pl[0])      chain0 <= plv;
    else if (se[0]) chain0 <= {sd[0], chain0[15:1]};
  end
  always @(posedge clk) begin
    if (pl[1])      chain1 <= plv[11:0];
    else if (se[1]) chain1 <= {sd[1], chain1[11:1]};
  end
  assign cr = {chain1[0], chain0[0]};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  bit         ob0[$], ob1[$];
  logic [7:0] orb0[$], orb1[$];
  always @(negedge clk) begin
    if (se[0])  ob0.push_back(sd[0]);
    if (se[1])  ob1.push_back(sd[1]);
    if (rbv[0]) orb0.push_back(rbd[0]);
    if (rbv[1]) orb1.push_back(rbd[1]);
  end

  logic [7:0]  txb[$];
  logic [15:0] chain_init;

  function automatic int len(input int k);
    return (k == 1) ? 12 : 16;
  endfunction

  function automatic logic [31:0] bcount(input int k);
    return (k == 1) ? 32'(bc1) : 32'(bc0);
  endfunction

  task automatic wait_ready(input int k);
    int t = 0;
    while (br[k] !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", 32'(br[k]), 32'd1);
  endtask

  task automatic do_load(input int k, input int stall_fixed, input int stall_rand);
    int L  = len(k);
    int nb = (L + 7) / 8;
    int t;
    logic [7:0]  cur;
    logic [7:0]  exp_rb;
    logic [15:0] exp_chain;
    logic [15:0] got_chain;
    bit          exp_bit;
    if (k == 0) begin ob0.delete(); orb0.delete(); end
    else        begin ob1.delete(); orb1.delete(); end
    @(negedge clk);
    plv   = chain_init;
    pl[k] = 1'b1;
    @(negedge clk);
    pl[k]      = 1'b0;
    start_s[k] = 1'b1;
    @(negedge clk);
    start_s[k] = 1'b0;
    check("start_to_ready", 32'(br[k]), 32'd1);
    check("start_clears_done", 32'(done_s[k]), 32'd0);
    check("start_clears_count", bcount(k), 32'd0);
    for (int b = 0; b < nb; b++) begin
      wait_ready(k);
      for (int s = 0; s < stall_fixed + int'($urandom_range(0, stall_rand)); s++) begin
        check("stall_ready", 32'(br[k]), 32'd1);
        check("stall_no_shift", 32'(se[k]), 32'd0);
        @(negedge clk);
      end
      bv[k] = 1'b1;
      bd[k] = txb[b];
      @(negedge clk);
      bv[k] = 1'b0;
      bd[k] = 8'($urandom);
    end
    t = 0;
    while (done_s[k] !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("done_reached", 32'(done_s[k]), 32'd1);
    @(negedge clk);
    check("final_count", bcount(k), 32'(L));
    check("final_busy", 32'(busy_s[k]), 32'd0);
    check("shift_cycles", (k == 0) ? 32'(ob0.size()) : 32'(ob1.size()), 32'(L));
    exp_chain = '0;
    for (int i = 0; i < L; i++) begin
      cur        = txb[i / 8];
      exp_bit    = cur[i % 8];
      exp_chain[i] = exp_bit;
      if (((k == 0) ? ob0.size() : ob1.size()) > i)
        check("stream_bit", (k == 0) ? 32'(ob0[i]) : 32'(ob1[i]), 32'(exp_bit));
    end
    check("readback_count", (k == 0) ? 32'(orb0.size()) : 32'(orb1.size()), 32'(nb));
    for (int j = 0; j < nb; j++) begin
      exp_rb = '0;
      for (int i = 8 * j; i < L && i < 8 * j + 8; i++) exp_rb[i - 8 * j] = chain_init[i];
      if (((k == 0) ? orb0.size() : orb1.size()) > j)
        check("readback_byte", (k == 0) ? 32'(orb0[j]) : 32'(orb1[j]), 32'(exp_rb));
    end
    got_chain = (k == 0) ? chain0 : {4'b0, chain1};
    check("chain_contents", 32'(got_chain), 32'(exp_chain));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    start_s = '0;
    bv      = '0;
    bd      = '0;

    // Reset with random inputs: all outputs held at 0.
    repeat (4) begin
      @(negedge clk);
      start_s = 2'($urandom);
      bv      = 2'($urandom);
      bd      = 16'($urandom);
      for (int k = 0; k < 2; k++) begin
        check("rst_ready", 32'(br[k]), 32'd0);
        check("rst_sdata", 32'(sd[k]), 32'd0);
        check("rst_senable", 32'(se[k]), 32'd0);
        check("rst_rbdata", 32'(rbd[k]), 32'd0);
        check("rst_rbvalid", 32'(rbv[k]), 32'd0);
        check("rst_busy", 32'(busy_s[k]), 32'd0);
        check("rst_done", 32'(done_s[k]), 32'd0);
        check("rst_count", bcount(k), 32'd0);
      end
    end
    @(negedge clk);
    start_s = '0;
    bv      = '0;
    reset   = 1'b0;
    @(negedge clk);
    check("idle_no_ready", 32'(br), 32'd0);
    start_s = 2'b11;
    @(negedge clk);
    start_s = '0;
    check("first_ready", 32'(br), 32'b11);
    check("load_busy", 32'(busy_s), 32'b11);
    pulse_reset();

    // Directed load of 0xA5, 0x3C over a chain preloaded with 0xBEEF.
    txb = '{8'hA5, 8'h3C};
    chain_init = 16'hBEEF;
    do_load(0, 0, 0);
    check("chain_3CA5", 32'(chain0), 32'h3CA5);

    // Short chain: final byte is partial.
    txb = '{8'hFF, 8'h0F};
    chain_init = 16'($urandom);
    do_load(1, 0, 0);

    // Same stream with a 5-cycle host stall before each byte, started from DONE.
    txb = '{8'hA5, 8'h3C};
    chain_init = 16'hBEEF;
    do_load(0, 5, 0);

    // Randomized loads with random stalls on both chain lengths.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 2; k++) begin
        txb = '{8'($urandom), 8'($urandom)};
        chain_init = 16'($urandom);
        do_load(k, 0, 3);
      end
    end

    // Reset three edges into the first byte's shift.
    @(negedge clk);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    wait_ready(0);
    bv[0] = 1'b1;
    bd[0] = 8'($urandom);
    @(negedge clk);
    bv[0] = 1'b0;
    check("midop_shifting", 32'(se[0]), 32'd1);
    repeat (3) @(posedge clk);
    #2;
    check("midop_count3", bcount(0), 32'd3);
    reset = 1'b1;
    #1;
    check("midop_rst_senable", 32'(se[0]), 32'd0);
    check("midop_rst_busy", 32'(busy_s[0]), 32'd0);
    check("midop_rst_ready", 32'(br[0]), 32'd0);
    check("midop_rst_count", bcount(0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    txb = '{8'($urandom), 8'($urandom)};
    chain_init = 16'($urandom);
    do_load(0, 0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
